neural_mac_unit: RTL
====================

Name: neural_mac_unit

Overview:
- Sequential, parametrised neuron. Accepts N_IN (input, weight) pairs over a valid/ready stream and accumulates the signed fixed-point dot product plus bias.
- Emits a 1-bit step activation f and a saturated W-bit sum y through an output valid/ready handshake.
- Successor to the fixed two-input combinational neuron. Building block for serialised NN layers on the FPGA.

Parameters:
- N_IN, 2, number of (x, w) pairs per neuron evaluation; ≥1
- W, 16, data/weight/bias width, signed two's complement
- FRAC, 8, fractional bits (Q(W-FRAC).FRAC; 1.0 = 1<<FRAC)
- ACC_W, 2*W+$clog2(N_IN+1), accumulator width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  x/w pair valid
- in_ready  out  1  unit can accept a pair
- x  in  W  signed input sample
- w  in  W  signed weight
- bias  in  W  signed bias; sampled on first accepted pair of each evaluation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- f  out  1  step activation: 1 iff final sum > 0
- y  out  W  final sum, saturated to W bits

Behaviour:
- Interface: one clock CLK; reset RST is synchronous, active-high.
- States: ACC, OUT. Reset → ACC, cnt=0, acc=0, out_valid=0, f=0, y=0. in_ready=0 while RST high.
- in_ready = (state==ACC) && !RST. out_valid = (state==OUT).
- Accept: in_valid && in_ready.
  - Product p = signed(x)*signed(w), 2W bits, arithmetic right shift by FRAC (floor, no rounding).
  - First pair (cnt==0): acc ← sext(bias) + p_shifted.
  - Other pairs: acc ← acc + p_shifted.
  - cnt increments on each accept.
- On accepting pair cnt==N_IN-1:
  - Next cycle state=OUT, cnt=0.
  - f = (sum > 0), where sum = acc + final product.
  - y = sat_W(sum): clamp to [-2^(W-1), 2^(W-1)-1].
  - f and y are registered, valid in the cycle after the last accept (latency 1).
- Sum exactly 0 → f=0.
- No accumulator wrap: ACC_W is sized for N_IN worst-case products.
- OUT: f, y held stable while out_ready=0; in_ready=0 (backpressure; no input accepted).
  - out_valid && out_ready → ACC next cycle; f, y retain their last values until the next result.
- in_valid low in ACC: acc and cnt hold. Gaps between pairs are allowed.
- Minimum period per evaluation: N_IN+1 cycles.
- RST mid-accumulation or in OUT: partial sum discarded, out_valid→0, state ACC, cnt=0 the next cycle.
- x, w, bias must be stable only in the accept cycle.

Optional Feature:
- Macro NEURAL_RELU_EN.
  - Defined: y = max(0, sat_W(sum)), so negative sums give y=0.
  - Undefined: y = sat_W(sum), signed.
- f is identical in both builds.

Decomposition:
- Package neural_pkg:
  - default W/FRAC constants and the Q-format ONE constant (1<<FRAC)
  - state enum {ACC, OUT}
  - saturation function sat_W
- Sub-module neural_sat: parametrised ACC_W→W signed saturator, reused by later layer blocks.
- FSM, counter and MAC stay in neural_mac_unit.

Test Plan:
- Defaults; pairs (0x0100,0x0100),(0x0100,0x0100), bias 0 → out_valid one cycle after 2nd accept, y=0x0200, f=1.
- Pairs (0x0100,0x0100),(0x0100,0xFF00), bias 0 → y=0x0000, f=0. Same pairs with bias 0xFF00 → y=0xFF00, f=0.
- Pairs (0x0F00,0x0100),(0x0F01,0xFF00) → y=0xFFFF, f=0. Swapped x values → y=0x0001, f=1.
- Pairs (0x7FFF,0x7FFF)×2 → y=0x7FFF, f=1.
  - Pairs (0x8000,0x7FFF)×2 → y=0x8000, f=0.
  - With NEURAL_RELU_EN the second case gives y=0x0000.
- Backpressure and stalls:
  - out_ready=0 for 5 cycles → out_valid, f, y stable; in_ready=0 throughout.
  - in_valid gaps between pairs → same result as without gaps.
- RST pulse after 1 of 2 pairs → next evaluation (0x0080,0x0100),(0x0100,0xFF00) gives y=0xFF80, f=0 with no residue from the aborted sum.

Source files
------------

// File: rtl/neural_pkg.sv
// ============================================================================
//  Module      : neural_pkg
//  Description : Shared Q-format constants, FSM state type and the generic
//                signed saturation helper for the neural building blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package neural_pkg;

    localparam int W_DEF    = 16;
    localparam int FRAC_DEF = 8;
    localparam int ONE      = 1 << FRAC_DEF;
    localparam int SAT_MAXW = 64;

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [SAT_MAXW-1:0] sat_w(
        input logic signed [SAT_MAXW-1:0] val,
        input int unsigned                width
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end else begin
            return val;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/neural_sat.sv
// ============================================================================
//  Module      : neural_sat
//  Description : Parametrised IN_W -> OUT_W signed two's-complement saturator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neural_sat
    import neural_pkg::*;
#(
    parameter int IN_W  = 34,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic        [OUT_W-1:0] o_val
);

    logic signed [SAT_MAXW-1:0] val_ext;
    logic signed [SAT_MAXW-1:0] val_sat;

    always_comb begin
        val_ext = SAT_MAXW'(i_val);
        val_sat = sat_w(val_ext, OUT_W);
        o_val   = OUT_W'(val_sat);
    end

endmodule

`default_nettype wire

// File: rtl/neural_mac_unit.sv
// ============================================================================
//  Module      : neural_mac_unit
//  Description : Sequential N_IN-input neuron: streamed signed MAC plus bias,
//                step activation f and saturated sum y. Optional macro
//                NEURAL_RELU_EN clamps negative y to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neural_mac_unit
    import neural_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int W     = W_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACC_W = 2 * W + $clog2(N_IN + 1)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] w,
    input  logic [W-1:0] bias,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         f,
    output logic [W-1:0] y
);

    localparam int             CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
`ifdef NEURAL_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     f_q, f_d;
    logic [W-1:0]             y_q, y_d;

    logic                     accept;
    logic signed [2*W-1:0]    prod;
    logic signed [2*W-1:0]    prod_sh;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  sum;
    logic [W-1:0]             sum_sat;
    logic [W-1:0]             y_res;

    assign in_ready  = (state_q == ST_ACC) && !RST;
    assign out_valid = (state_q == ST_OUT);
    assign accept    = in_valid && in_ready;
    assign f         = f_q;
    assign y         = y_q;

    // Floor (arithmetic shift) back to Q-format; bias joins on the first pair.
    always_comb begin
        prod    = $signed(x) * $signed(w);
        prod_sh = prod >>> FRAC;
        base    = (cnt_q == '0) ? ACC_W'($signed(bias)) : acc_q;
        sum     = base + ACC_W'(prod_sh);
    end

    neural_sat #(
        .IN_W  (ACC_W),
        .OUT_W (W)
    ) u_sat (
        .i_val (sum),
        .o_val (sum_sat)
    );

    assign y_res = (RELU_EN && sum_sat[W-1]) ? '0 : sum_sat;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        f_d     = f_q;
        y_d     = y_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    acc_d = sum;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_OUT;
                        f_d     = !sum[ACC_W-1] && (sum != '0);
                        y_d     = y_res;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            f_q     <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            f_q     <= f_d;
            y_q     <= y_d;
        end
    end

endmodule

`default_nettype wire
